// File: rtl/calc_pkg.sv
// Shared encodings for the calculator execute controller: operation codes and FSM states.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/calc_muldiv.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per step.
// Both iterations advance together; the controller picks whichever result its state needs.
module calc_muldiv
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] mul_next,
  output logic [WIDTH-1:0]   quot_next
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   rem_next;

  // diff[WIDTH] set means the trial subtraction went negative, so restore
  assign mul_next  = acc + (mplier[0] ? mcand : '0);
  assign shifted   = {rem, quo[WIDTH-1]};
  assign diff      = shifted - {1'b0, divisor};
  assign quot_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
  assign rem_next  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign last      = (count == CW'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
    end else if (load) begin
      count   <= '0;
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      rem     <= '0;
      quo     <= a;
      divisor <= b;
    end else if (step) begin
      count   <= count + 1'b1;
      acc     <= mul_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      rem     <= rem_next;
      quo     <= quot_next;
    end
  end

endmodule

// File: rtl/calc_exec_ctrl.sv
// Execute controller for the calculator: runs one operation per "equals" press and
// hands the result back to the operand registers with a single completion pulse.
module calc_exec_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             div_zero,
  output logic             load_result_A,
  output logic             clear_B
);

  state_t               state;
  state_t               state_next;
  logic                 load;
  logic                 step;
  logic                 last;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH-1:0]     quot_next;
  logic [WIDTH:0]       sum;
  logic                 accept;

  assign sum    = {1'b0, operand_a} + {1'b0, operand_b};
  assign accept = (state == IDLE) && start;

  calc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .a         (operand_a),
    .b         (operand_b),
    .last      (last),
    .mul_next  (mul_next),
    .quot_next (quot_next)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op_t'(op))
            OP_ADD, OP_SUB: state_next = DONE;
            OP_MUL: begin
              load       = 1'b1;
              state_next = MUL;
            end
            OP_DIV: begin
              if (operand_b == '0) begin
                state_next = DONE;
              end else begin
                load       = 1'b1;
                state_next = DIV;
              end
            end
          endcase
        end
      end
      MUL, DIV: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: state_next = IDLE;
    endcase
  end

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign load_result_A = done;
  assign clear_B       = done;

  // Result and flags change only on the edge entering DONE, so they stay stable between dones
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      result   <= '0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        case (op_t'(op))
          OP_ADD: begin
            result   <= sum[WIDTH-1:0];
            overflow <= sum[WIDTH];
            div_zero <= 1'b0;
          end
          OP_SUB: begin
            result   <= operand_a - operand_b;
            overflow <= (operand_a < operand_b);
            div_zero <= 1'b0;
          end
          OP_DIV: begin
            if (operand_b == '0) begin
              result   <= '0;
              overflow <= 1'b0;
              div_zero <= 1'b1;
            end
          end
          OP_MUL: ;
        endcase
      end else if (step && last) begin
        overflow <= (state == MUL) ? (|mul_next[2*WIDTH-1:WIDTH]) : 1'b0;
        result   <= (state == MUL) ? mul_next[WIDTH-1:0] : quot_next;
        div_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_calc_exec_ctrl.sv
// Self-checking bench for calc_exec_ctrl: directed corner cases plus random operations
// compared against plain-arithmetic expectations.
module tb_calc_exec_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        overflow;
  logic        div_zero;
  logic        load_result_A;
  logic        clear_B;

  int checks = 0;
  int errors = 0;

  calc_exec_ctrl #(.WIDTH(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .op            (op),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .overflow      (overflow),
    .div_zero      (div_zero),
    .load_result_A (load_result_A),
    .clear_B       (clear_B)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one request at the current (idle) negedge, optionally pokes start again
  // mid-operation, then checks the completion cycle against arithmetic expectations.
  task automatic applyStimulus(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                               input int inject_at);
    int unsigned full;
    int unsigned exp_res, exp_ovf, exp_dz, exp_lat;
    int cycles, busy_cnt;
    case (o)
      2'd0: begin full = int'(a) + int'(b); exp_res = full & 32'hFFFF; exp_ovf = (full > 32'hFFFF) ? 1 : 0; exp_dz = 0; exp_lat = 1; end
      2'd1: begin exp_res = (int'(a) - int'(b)) & 32'hFFFF; exp_ovf = (a < b) ? 1 : 0; exp_dz = 0; exp_lat = 1; end
      2'd2: begin full = int'(a) * int'(b); exp_res = full & 32'hFFFF; exp_ovf = ((full >> 16) != 0) ? 1 : 0; exp_dz = 0; exp_lat = 17; end
      default: begin
        if (b == 16'd0) begin exp_res = 0; exp_ovf = 0; exp_dz = 1; exp_lat = 1; end
        else begin exp_res = int'(a) / int'(b); exp_ovf = 0; exp_dz = 0; exp_lat = 17; end
      end
    endcase
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clock);
    start = 1'b0;
    cycles = 1;
    busy_cnt = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      operand_a = 16'($urandom);
      operand_b = 16'($urandom);
      op = 2'($urandom);
      start = (cycles == inject_at);
      @(negedge clock);
      start = 1'b0;
      cycles++;
    end
    if (busy) busy_cnt++;
    checkOutput("done", 32'(done), 1);
    checkOutput("latency", cycles, exp_lat);
    checkOutput("busy_cycles", busy_cnt, exp_lat);
    checkOutput("result", 32'(result), exp_res);
    checkOutput("overflow", 32'(overflow), exp_ovf);
    checkOutput("div_zero", 32'(div_zero), exp_dz);
    checkOutput("load_result_A", 32'(load_result_A), 1);
    checkOutput("clear_B", 32'(clear_B), 1);
    @(negedge clock);
    checkOutput("done_one_cycle", 32'(done), 0);
    checkOutput("idle_after_done", 32'(busy), 0);
    checkOutput("result_held", 32'(result), exp_res);
  endtask

  initial begin
    int done_seen;
    logic [1:0]  ro;
    logic [15:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 2'd0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_result", 32'(result), 0);
    checkOutput("reset_flags", {30'd0, overflow, div_zero}, 0);
    checkOutput("reset_pulses", {30'd0, load_result_A, clear_B}, 0);
    reset = 1'b0;

    applyStimulus(2'd0, 16'hFFFF, 16'h0002, 0);
    applyStimulus(2'd1, 16'd5, 16'd7, 0);
    applyStimulus(2'd1, 16'd7, 16'd5, 0);
    applyStimulus(2'd2, 16'd300, 16'd300, 0);
    applyStimulus(2'd3, 16'd100, 16'd7, 0);
    applyStimulus(2'd3, 16'd5, 16'd0, 0);
    applyStimulus(2'd2, 16'd300, 16'd300, 5);
    applyStimulus(2'd2, 16'd255, 16'd255, 0);
    applyStimulus(2'd3, 16'hFFFF, 16'd1, 0);
    applyStimulus(2'd3, 16'd3, 16'hFFFF, 0);
    applyStimulus(2'd2, 16'hFFFF, 16'hFFFF, 0);
    applyStimulus(2'd0, 16'h1234, 16'h0001, 0);

    for (int i = 0; i < 48; i++) begin
      ro = 2'($urandom);
      ra = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if (ro == 2'd3 && $urandom_range(0, 7) == 0) rb = 16'd0;
      applyStimulus(ro, ra, rb, int'($urandom_range(0, 12)));
    end

    // Reset in the middle of a divide must abort silently
    start = 1'b1; op = 2'd3; operand_a = 16'd1000; operand_b = 16'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    checkOutput("div_busy_cycle8", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_result", 32'(result), 0);
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (done || load_result_A || clear_B || busy) done_seen++;
      @(negedge clock);
    end
    checkOutput("abort_no_pulse", done_seen, 0);

    // Reset wins over a simultaneous start
    reset = 1'b1; start = 1'b1; op = 2'd0; operand_a = 16'd1; operand_b = 16'd1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    checkOutput("rst_start_busy", 32'(busy), 0);
    @(negedge clock);
    checkOutput("rst_start_done", 32'(done), 0);
    checkOutput("rst_start_result", 32'(result), 0);

    applyStimulus(2'd3, 16'd100, 16'd7, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
